leg_io_responder: RTL
=====================

# leg_io_responder

Host-side responder for the LEG core's architectural I/O port. It answers the core's `arch_input_enable` reads from a byte input FIFO filled by a host valid/ready stream. It captures every `arch_output_enable` write into a byte output FIFO, which the host drains through a second valid/ready stream. It sits between the LEG top level and the testbench or level harness, and keeps sticky underflow/overflow flags and transfer counters for checking.

## Interface
Parameters:
- `UUID`, 0, instance identifier; no functional effect.
- `IN_DEPTH`, 4, input FIFO entries; power of two, 2..16.
- `OUT_DEPTH`, 4, output FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `arch_input_enable`  in  1  core is reading input this cycle.
- `arch_input_value`  out  8  byte presented to the core.
- `arch_output_enable`  in  1  core is writing output this cycle.
- `arch_output_value`  in  8  byte written by the core.
- `in_valid`  in  1  host offers `in_data`.
- `in_data`  in  8  host input byte.
- `in_ready`  out  1  input FIFO can accept.
- `out_valid`  out  1  output FIFO non-empty.
- `out_data`  out  8  head of output FIFO.
- `out_ready`  in  1  host consumes `out_data`.
- `in_level`  out  clog2(IN_DEPTH)+1  input FIFO occupancy.
- `out_level`  out  clog2(OUT_DEPTH)+1  output FIFO occupancy.
- `underflow`  out  1  sticky: core read while input FIFO empty.
- `overflow`  out  1  sticky: core wrote while output FIFO full.
- `err_clr`  in  1  synchronous clear of both sticky flags.
- `rd_count`  out  8  core reads served from data, wraps mod 256.
- `wr_count`  out  8  core writes accepted, wraps mod 256.

## Operation
- Input FIFO:
  - Host push occurs when `in_valid & in_ready`; `in_ready = (in_level != IN_DEPTH)`.
  - `arch_input_value` is combinational: the FIFO head when non-empty, otherwise 8'h00.
  - A core read (`arch_input_enable`=1) pops the head at the clock edge when non-empty and increments `rd_count`.
  - A core read while empty leaves the FIFO unchanged, sets `underflow`, and returns 0x00.
- Output FIFO:
  - A core write (`arch_output_enable`=1) pushes `arch_output_value` at the edge when not full and increments `wr_count`.
  - A core write while full drops the byte and sets `overflow`; the FIFO contents are unchanged.
  - Host pop occurs when `out_valid & out_ready`; `out_data` is the head, and 8'h00 when empty.
- Simultaneous events:
  - Input push and pop in the same cycle while non-empty: both occur and the level is unchanged.
  - Input push and pop in the same cycle while empty: there is no bypass. The read returns 0x00 and sets `underflow`; the push is stored and the level becomes 1.
  - Output push and pop in the same cycle while full: `out_ready` does not make room in that cycle. The write is dropped and `overflow` is set; the pop proceeds and the level becomes OUT_DEPTH-1.
  - Output push and pop in the same cycle otherwise: both occur.
- Flags:
  - `err_clr` clears both flags.
  - If `err_clr` and a new error occur in the same cycle, the set wins.
- Pointers wrap modulo depth; levels never exceed depth.
- Reset (`rst`=0, asynchronous, effective mid-transfer):
  - Pointers, levels, counters and flags go to 0; FIFO contents are discarded.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `arch_input_value`=0x00, `out_data`=0x00.

## Timing
- Core read: data is visible in the same cycle the enable is asserted. The pop takes effect at that cycle's edge, and the next byte is visible in the following cycle.
- Host input: a byte pushed at edge N is readable by the core in cycle N+1. `in_level` updates at edge N.
- Core write: a byte written at edge N appears on `out_data` and `out_valid` from cycle N+1.
- `in_ready`, `out_valid`, the levels, counters and flags are all registered-state derived, with no combinational path from the enables to `in_ready` or `out_valid`.
- Every cycle can sustain one core read, one core write, one host push and one host pop.

## Test plan
- Reset check: assert `rst`=0 asynchronously mid-transfer -> all outputs immediately at their reset values (`in_ready`=1, levels 0, flags 0, `arch_input_value`=0x00); after release the FIFOs are empty.
- Input path: push 0x11, 0x22, 0x33, 0x44, then core reads 4 consecutive cycles -> `arch_input_value` sequence 11,22,33,44; `rd_count`=4; `in_ready` was 0 only while `in_level`=4 (IN_DEPTH=4).
- Underflow: core read with empty FIFO -> `arch_input_value`=0x00, `underflow`=1, `rd_count` unchanged; `err_clr` pulse -> `underflow`=0.
- Output path: core writes 0xA5, 0x5A with `out_ready`=0 -> `out_level`=2; raise `out_ready` -> `out_data` 0xA5 then 0x5A; `wr_count`=2.
- Overflow: fill the output FIFO with 4 writes, then a 5th write 0xFF together with `out_ready`=1 -> 0xFF dropped, `overflow`=1, `out_level`=3, `wr_count`=4.
- Concurrency plus wrap: run continuous push/pop on both FIFOs for 300 bytes -> data order preserved across pointer wrap; `rd_count` and `wr_count` both equal 300 mod 256 = 44.

Source files
------------

// File: rtl/leg_io_responder.sv
// leg_io_responder: host-side responder for the LEG core architectural I/O port.
// Byte input/output FIFOs with sticky error flags and transfer counters.
module leg_io_responder #(
  parameter int UUID      = 0,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arch_input_enable,
  output logic [7:0]                   arch_input_value,
  input  logic                         arch_output_enable,
  input  logic [7:0]                   arch_output_value,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  input  logic                         out_ready,
  output logic [$clog2(IN_DEPTH):0]    in_level,
  output logic [$clog2(OUT_DEPTH):0]   out_level,
  output logic                         underflow,
  output logic                         overflow,
  input  logic                         err_clr,
  output logic [7:0]                   rd_count,
  output logic [7:0]                   wr_count
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int ILW = IAW + 1;
  localparam int OLW = OAW + 1;
  localparam logic [IAW:0] IN_FULL  = IN_DEPTH[IAW:0];
  localparam logic [OAW:0] OUT_FULL = OUT_DEPTH[OAW:0];

  // UUID only tags the instance
  if (UUID < 0) begin : g_uuid
  end

  logic [7:0]     in_mem  [IN_DEPTH];
  logic [7:0]     out_mem [OUT_DEPTH];
  logic [IAW-1:0] in_wp;
  logic [IAW-1:0] in_rp;
  logic [OAW-1:0] out_wp;
  logic [OAW-1:0] out_rp;

  logic in_empty;
  logic out_full;
  logic in_push;
  logic in_pop;
  logic out_push;
  logic out_pop;
  logic uf_set;
  logic of_set;

  assign in_empty  = (in_level == '0);
  assign out_full  = (out_level == OUT_FULL);
  assign in_ready  = (in_level != IN_FULL);
  assign out_valid = (out_level != '0);

  assign in_push  = in_valid & in_ready;
  assign in_pop   = arch_input_enable & ~in_empty;
  assign out_push = arch_output_enable & ~out_full;
  assign out_pop  = out_valid & out_ready;
  assign uf_set   = arch_input_enable & in_empty;
  assign of_set   = arch_output_enable & out_full;

  assign arch_input_value = in_empty ? 8'h00 : in_mem[in_rp];
  assign out_data         = out_valid ? out_mem[out_rp] : 8'h00;

  // contents need no reset: reads are gated by the levels
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem[in_wp] <= in_data;
    end
    if (out_push) begin
      out_mem[out_wp] <= arch_output_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wp    <= '0;
      in_rp    <= '0;
      in_level <= '0;
      rd_count <= '0;
    end else begin
      if (in_push) begin
        in_wp <= in_wp + IAW'(1);
      end
      if (in_pop) begin
        in_rp    <= in_rp + IAW'(1);
        rd_count <= rd_count + 8'd1;
      end
      in_level <= in_level + ILW'(in_push) - ILW'(in_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wp    <= '0;
      out_rp    <= '0;
      out_level <= '0;
      wr_count  <= '0;
    end else begin
      if (out_push) begin
        out_wp   <= out_wp + OAW'(1);
        wr_count <= wr_count + 8'd1;
      end
      if (out_pop) begin
        out_rp <= out_rp + OAW'(1);
      end
      out_level <= out_level + OLW'(out_push) - OLW'(out_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (uf_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
      if (of_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
